// File: rtl/masked_mul_scheduler_pkg.sv
// Shared definitions for the masked multiplier scheduler.
// num_quad    : number of fresh random share-pairs a DOM-style product needs,
//               one per unordered pair of shares.
// pair_index  : position of the pair (lo, hi), lo < hi, inside that p vector.
package masked_mul_scheduler_pkg;

  function automatic int num_quad(input int num_shares);
    return (num_shares * (num_shares - 1)) / 2;
  endfunction

  function automatic int pair_index(input int lo, input int hi, input int num_shares);
    return (lo * num_shares) - ((lo * (lo + 1)) / 2) + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/masked_mul_scheduler_hpc1_mul.sv
// masked_hpc1_mul: two-cycle Boolean-masked AND/multiply of shared operands.
// Cycle t   : b and r are presented; b is refreshed with r and registered.
// Cycle t+1 : a and p are presented; all cross-domain partial products are
//             remasked with p and registered.
// Cycle t+2 : c is the XOR compression of the registered partial products.
// Ports: clk, rst (async active-high), a/b/c (NUM_SHARES x BIT_WIDTH),
//        r (NUM_SHARES x BIT_WIDTH), p (num_quad(NUM_SHARES) x BIT_WIDTH).
module masked_hpc1_mul
  import masked_mul_scheduler_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]               a,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]               b,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]               r,
  input  logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0]     p,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]               c
);

  localparam int SHARE_W = NUM_SHARES * BIT_WIDTH;

  logic [SHARE_W-1:0]   b_ref_s;
  logic [SHARE_W-1:0]   b_ref_r;
  logic [BIT_WIDTH-1:0] term_s [NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] term_r [NUM_SHARES][NUM_SHARES];
  logic [SHARE_W-1:0]   c_s;

  // Ring refresh of b: each r share lands in two neighbouring b shares, so the
  // unshared value of b is preserved.
  always_comb begin
    b_ref_s = {SHARE_W{1'b0}};
    for (int i = 0; i < NUM_SHARES; i++) begin
      b_ref_s[i*BIT_WIDTH +: BIT_WIDTH] = b[i*BIT_WIDTH +: BIT_WIDTH]
                                        ^ r[i*BIT_WIDTH +: BIT_WIDTH]
                                        ^ r[((i + 1) % NUM_SHARES)*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Register the refreshed b so it meets a one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_ref_r <= {SHARE_W{1'b0}};
    end else begin
      b_ref_r <= b_ref_s;
    end
  end

  // Partial products; (i,j) and (j,i) share one p word so the mask cancels.
  always_comb begin
    for (int i = 0; i < NUM_SHARES; i++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        if (i == j) begin
          term_s[i][j] = a[i*BIT_WIDTH +: BIT_WIDTH] & b_ref_r[j*BIT_WIDTH +: BIT_WIDTH];
        end else if (i < j) begin
          term_s[i][j] = (a[i*BIT_WIDTH +: BIT_WIDTH] & b_ref_r[j*BIT_WIDTH +: BIT_WIDTH])
                       ^ p[pair_index(i, j, NUM_SHARES)*BIT_WIDTH +: BIT_WIDTH];
        end else begin
          term_s[i][j] = (a[i*BIT_WIDTH +: BIT_WIDTH] & b_ref_r[j*BIT_WIDTH +: BIT_WIDTH])
                       ^ p[pair_index(j, i, NUM_SHARES)*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  // Register every partial product before compression to stop glitch leakage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SHARES; i++) begin
        for (int j = 0; j < NUM_SHARES; j++) begin
          term_r[i][j] <= {BIT_WIDTH{1'b0}};
        end
      end
    end else begin
      term_r <= term_s;
    end
  end

  // Compress each output share's row of registered partial products.
  always_comb begin
    c_s = {SHARE_W{1'b0}};
    for (int i = 0; i < NUM_SHARES; i++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        c_s[i*BIT_WIDTH +: BIT_WIDTH] = c_s[i*BIT_WIDTH +: BIT_WIDTH] ^ term_r[i][j];
      end
    end
  end

  assign c = c_s;

endmodule

// File: rtl/masked_mul_scheduler.sv
// masked_mul_scheduler: issues shared operand pairs with fresh randomness into
// one masked_hpc1_mul and buffers the products in an in-order result FIFO.
// Ports: in_clock/in_reset (async active-high); in_a/in_b/in_valid/in_ready
// operand handshake; rnd_data/rnd_valid/rnd_ready randomness handshake (low
// NUM_SHARES*BIT_WIDTH bits = r, rest = p); out_c/out_valid/out_ready result
// handshake; busy while anything is in flight or buffered.
module masked_mul_scheduler
  import masked_mul_scheduler_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                                   in_clock,
  input  logic                                                   in_reset,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]                        in_a,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]                        in_b,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [(NUM_SHARES+num_quad(NUM_SHARES))*BIT_WIDTH-1:0] rnd_data,
  input  logic                                                   rnd_valid,
  output logic                                                   rnd_ready,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]                        out_c,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic                                                   busy
);

  localparam int SHARE_W = NUM_SHARES * BIT_WIDTH;
  localparam int P_W     = num_quad(NUM_SHARES) * BIT_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic               v1_r;
  logic               v2_r;
  logic [SHARE_W-1:0] a_hold_r;
  logic [P_W-1:0]     p_hold_r;
  logic [CNT_W-1:0]   count_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [SHARE_W-1:0] fifo_mem_r [FIFO_DEPTH];

  logic [CNT_W:0]     occupancy_s;
  logic               space_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;
  logic [SHARE_W-1:0] mul_a_s;
  logic [SHARE_W-1:0] mul_b_s;
  logic [SHARE_W-1:0] mul_r_s;
  logic [P_W-1:0]     mul_p_s;
  logic [SHARE_W-1:0] mul_c_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Capacity is reserved for in-flight operations, so the FIFO cannot overflow.
  assign occupancy_s = {{CNT_W{1'b0}}, v1_r} + {{CNT_W{1'b0}}, v2_r} + {1'b0, count_r};
  assign space_s     = (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH));
  assign in_ready    = rnd_valid && space_s;
  assign rnd_ready   = in_valid && space_s;
  assign issue_s     = in_valid && in_ready;
  assign push_s      = v2_r;
  assign out_valid   = (count_r != {CNT_W{1'b0}});
  assign pop_s       = out_valid && out_ready;
  assign busy        = v1_r || v2_r || out_valid;
  assign out_c       = out_valid ? fifo_mem_r[rd_ptr_r] : {SHARE_W{1'b0}};

  // Multiplier inputs are zeroed whenever their pipeline slot is empty.
  assign mul_b_s = issue_s ? in_b : {SHARE_W{1'b0}};
  assign mul_r_s = issue_s ? rnd_data[SHARE_W-1:0] : {SHARE_W{1'b0}};
  assign mul_a_s = v1_r ? a_hold_r : {SHARE_W{1'b0}};
  assign mul_p_s = v1_r ? p_hold_r : {P_W{1'b0}};

  // S1 holding register and valid pipeline tracking the multiplier latency.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      a_hold_r <= {SHARE_W{1'b0}};
      p_hold_r <= {P_W{1'b0}};
    end else begin
      v1_r     <= issue_s;
      v2_r     <= v1_r;
      a_hold_r <= issue_s ? in_a : {SHARE_W{1'b0}};
      p_hold_r <= issue_s ? rnd_data[SHARE_W +: P_W] : {P_W{1'b0}};
    end
  end

  // FIFO occupancy and pointers.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      wr_ptr_r <= push_s ? ptr_next(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s ? ptr_next(rd_ptr_r) : rd_ptr_r;
    end
  end

  // FIFO storage; stale contents are masked by out_valid, so no reset needed.
  always_ff @(posedge in_clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= mul_c_s;
    end
  end

  masked_hpc1_mul #(
    .NUM_SHARES (NUM_SHARES),
    .BIT_WIDTH  (BIT_WIDTH)
  ) u_mul (
    .clk (in_clock),
    .rst (in_reset),
    .a   (mul_a_s),
    .b   (mul_b_s),
    .r   (mul_r_s),
    .p   (mul_p_s),
    .c   (mul_c_s)
  );

endmodule

// File: tb/tb_masked_mul_scheduler.sv
module tb_masked_mul_scheduler;

  logic       in_clock = 1'b0;
  logic       in_reset;
  logic [1:0] in_a;
  logic [1:0] in_b;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [1:0] out_c;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int issue_cnt = 0;
  logic sb_q [$];

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] rnd;
    logic       exp_c;
  } vec_t;
  vec_t vecs [8];

  masked_mul_scheduler #(
    .NUM_SHARES (2),
    .BIT_WIDTH  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .out_c     (out_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 in_clock = ~in_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push the unshared product on issue, compare on every pop.
  always @(negedge in_clock) begin
    if (in_reset) begin
      sb_q.delete();
    end else begin
      check("rnd_consumed_iff_issue", 32'(rnd_valid && rnd_ready), 32'(in_valid && in_ready));
      if (in_valid && in_ready) begin
        sb_q.push_back((in_a[0] ^ in_a[1]) & (in_b[0] ^ in_b[1]));
        issue_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(1), 32'(0));
        end else begin
          check("sb_product", 32'(out_c[0] ^ out_c[1]), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic [1:0] a, input logic [1:0] b,
                       input logic [2:0] rnd, input logic rv, input logic ordy);
    @(posedge in_clock);
    #1;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    rnd_data  = rnd;
    rnd_valid = rv;
    out_ready = ordy;
  endtask

  task automatic run_vec(input logic [1:0] a, input logic [1:0] b,
                         input logic [2:0] rnd, input logic exp_c);
    drive(1'b1, a, b, rnd, 1'b1, 1'b1);
    @(negedge in_clock);
    check("vec_issue", 32'(in_ready), 32'(1));
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1);
      @(negedge in_clock);
      check("vec_latency", 32'(out_valid), 32'(k == 3));
      if (k == 3) begin
        check("vec_product", 32'(out_c[0] ^ out_c[1]), 32'(exp_c));
      end
    end
    drive(1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1);
    @(negedge in_clock);
    check("vec_busy_after_pop", 32'(busy), 32'(0));
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1);
      @(negedge in_clock);
      if (!busy && sb_q.size() == 0) break;
    end
    check("drain_busy", 32'(busy), 32'(0));
    check("drain_queue", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    vecs[0] = '{a: 2'b01, b: 2'b10, rnd: 3'b101, exp_c: 1'b1};
    vecs[1] = '{a: 2'b11, b: 2'b01, rnd: 3'b011, exp_c: 1'b0};
    vecs[2] = '{a: 2'b10, b: 2'b11, rnd: 3'b110, exp_c: 1'b0};
    vecs[3] = '{a: 2'b10, b: 2'b01, rnd: 3'b111, exp_c: 1'b1};
    vecs[4] = '{a: 2'b00, b: 2'b10, rnd: 3'b001, exp_c: 1'b0};
    vecs[5] = '{a: 2'b01, b: 2'b00, rnd: 3'b100, exp_c: 1'b0};
    vecs[6] = '{a: 2'b11, b: 2'b11, rnd: 3'b010, exp_c: 1'b0};
    vecs[7] = '{a: 2'b10, b: 2'b10, rnd: 3'b000, exp_c: 1'b1};

    in_reset = 1'b1; in_valid = 1'b0; in_a = 2'b00; in_b = 2'b00;
    rnd_data = 3'b000; rnd_valid = 1'b1; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge in_clock);
    @(negedge in_clock);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_c", 32'(out_c), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    drive(1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
    @(negedge in_clock);
    check("rst_rnd_ready", 32'(rnd_ready), 32'(1));
    check("rst_in_ready_norand", 32'(in_ready), 32'(0));
    drive(1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1);
    in_reset = 1'b0;

    // Table-driven single operations (first entry: a=(1,0), b=(0,1))
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].rnd, vecs[i].exp_c);
    end

    // Streaming: 16 back-to-back ops
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'($urandom), 2'($urandom), 3'($urandom), 1'b1, 1'b1);
      @(negedge in_clock);
      check("stream_in_ready", 32'(in_ready), 32'(1));
    end
    drain();

    // Randomness starvation
    start = issue_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b01, 2'b01, 3'b010, 1'b0, 1'b1);
      @(negedge in_clock);
      check("starve_in_ready", 32'(in_ready), 32'(0));
      check("starve_rnd_ready", 32'(rnd_ready), 32'(1));
    end
    check("starve_no_issue", 32'(issue_cnt - start), 32'(0));
    drive(1'b1, 2'b01, 2'b01, 3'b010, 1'b1, 1'b1);
    @(negedge in_clock);
    check("starve_release_ready", 32'(in_ready), 32'(1));
    drive(1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1);
    @(negedge in_clock);
    check("starve_one_issue", 32'(issue_cnt - start), 32'(1));
    drain();

    // Backpressure
    start = issue_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'($urandom), 2'($urandom), 3'($urandom), 1'b1, 1'b0);
      @(negedge in_clock);
    end
    check("bp_in_ready_low", 32'(in_ready), 32'(0));
    check("bp_out_valid", 32'(out_valid), 32'(1));
    check("bp_issue_count", 32'(issue_cnt - start), 32'(4));
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 2'($urandom), 2'($urandom), 3'($urandom), 1'b1, 1'b1);
      @(negedge in_clock);
    end
    drive(1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1);
    @(negedge in_clock);
    check("bp_resumed", 32'((issue_cnt - start) > 4), 32'(1));
    drain();

    // Reset mid-operation
    drive(1'b1, 2'b01, 2'b10, 3'b011, 1'b1, 1'b1);
    @(negedge in_clock);
    check("midrst_issue", 32'(in_ready), 32'(1));
    @(posedge in_clock);
    #1;
    in_reset = 1'b1;
    in_valid = 1'b0;
    @(negedge in_clock);
    check("midrst_busy_in_reset", 32'(busy), 32'(0));
    @(posedge in_clock);
    #1;
    in_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clock);
      check("midrst_no_output", 32'(out_valid), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
    end
    run_vec(vecs[3].a, vecs[3].b, vecs[3].rnd, vecs[3].exp_c);

    check("final_queue_empty", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/masked_mul_scheduler.md
MASKED_MUL_SCHEDULER -- requirements
Module: masked_mul_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SHARES, default 2, giving the number of Boolean shares per operand.
REQ-002 The block SHALL have parameter BIT_WIDTH, default 1, giving the width of each share.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the result buffer depth; legal values are 1 or more.
REQ-004 Port in_clock, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 Port in_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_a, input, NUM_SHARES x BIT_WIDTH: shares of operand a.
REQ-007 Port in_b, input, NUM_SHARES x BIT_WIDTH: shares of operand b.
REQ-008 Port in_valid, input, 1 bit: operand pair offered. Port in_ready, output, 1 bit: operand pair accepted.
REQ-009 Port rnd_data, input, (NUM_SHARES+NUM_QUAD) x BIT_WIDTH: fresh randomness. The low NUM_SHARES x BIT_WIDTH bits are r; the remaining bits are p.
REQ-010 Port rnd_valid, input, 1 bit; port rnd_ready, output, 1 bit: randomness handshake.
REQ-011 Port out_c, output, NUM_SHARES x BIT_WIDTH: shares of the product.
REQ-012 Port out_valid, input-side ports out_ready: out_valid is an output, 1 bit; out_ready is an input, 1 bit; together they form the result handshake.
REQ-013 Port busy, output, 1 bit: high while any operation is in flight or buffered.

Function
REQ-014 Define space = (inflight + count < FIFO_DEPTH), where inflight counts the valid bits in stages S1 and S2 and count is the FIFO occupancy.
REQ-015 in_ready SHALL equal rnd_valid && space, and rnd_ready SHALL equal in_valid && space; neither SHALL depend combinationally on its own valid signal.
REQ-016 An issue SHALL occur in a cycle where in_valid && in_ready; exactly one rnd_data word SHALL be consumed per issue and none otherwise.
REQ-017 In the issue cycle t, the block SHALL drive in_b and r to the multiplier's b and r inputs, and SHALL latch in_a and p into the S1 holding register with v1 set.
REQ-018 In cycle t+1, the held a and p SHALL drive the multiplier's a and p inputs.
REQ-019 When no operation sits in S1, the multiplier's a and p inputs SHALL be held at zero; the b and r inputs SHALL be zero when no issue occurs.
REQ-020 v1 SHALL advance to v2 each cycle; the multiplier result SHALL be valid in cycle t+2, and SHALL be written into the FIFO in that cycle when v2 is set.
REQ-021 The fixed issue-to-FIFO-write latency SHALL be 2 cycles, and the earliest out_valid SHALL occur in cycle t+3.
REQ-022 The FIFO SHALL be first-in first-out: out_valid = (count != 0) and out_c = head entry. A pop occurs on out_valid && out_ready.
REQ-023 A simultaneous write and pop SHALL leave count unchanged. A pop and write on an empty FIFO SHALL never happen in the same cycle, because writes become visible next cycle.
REQ-024 Because space reserves capacity for in-flight operations, the FIFO SHALL never overflow; a write when count == FIFO_DEPTH is an assertion failure.
REQ-025 With FIFO_DEPTH >= 4 and out_ready held high, the block SHALL sustain one issue per cycle.
REQ-026 Results SHALL leave in issue order, and the unshared value of out_c SHALL equal the product of the unshared a and b.
REQ-027 busy SHALL equal v1 || v2 || (count != 0).

Reset
REQ-028 Asserting in_reset SHALL immediately clear v1, v2, count, the FIFO pointers and the S1 holding register. Operations in flight are discarded and no output is produced for them.
REQ-029 While and after reset, out_valid = 0, out_c = 0 and busy = 0; in_ready and rnd_ready follow REQ-015 with space = 1.
REQ-030 The block SHALL pass in_reset to the multiplier instance.

Structure
REQ-031 NUM_QUAD SHALL come from the shared package function num_quad(NUM_SHARES); no new package constants are required.
REQ-032 The block SHALL instantiate exactly one masked_hpc1_mul as its sub-module; the FIFO and control logic SHALL be local.

Verification (NUM_SHARES=2, BIT_WIDTH=1)
REQ-033 Single op: after reset, issue a=(1,0), b=(0,1) with rnd random -> out_valid rises exactly 3 cycles after the issue, out_c[0]^out_c[1]=1, and busy falls after the pop.
REQ-034 Streaming: 16 back-to-back random ops with out_ready=1 and rnd_valid=1 -> in_ready stays high throughout, all 16 products are correct and in order.
REQ-035 Randomness starvation: in_valid=1 with rnd_valid=0 for 5 cycles -> in_ready=0, no issue occurs and no rnd consumed; rnd_valid=1 -> issue in the same cycle.
REQ-036 Backpressure: out_ready=0 while issuing continuously -> exactly FIFO_DEPTH (4) issues occur, then in_ready=0; out_ready=1 -> 4 correct results drain and issuing resumes.
REQ-037 Reset mid-operation: assert in_reset in cycle t+1 after an issue -> out_valid is never asserted for that op, busy=0, and the next op completes correctly.
